// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: captures an OV7670-style camera byte stream into a linear
// frame buffer. The camera pins are sampled as data in the clk domain. Byte
// pairs are packed into RGB444 pixels and written out with one-cycle strobes.
// Build option: define CAP_TESTPAT_EN to add the cap_tp colour-bar input.
//
// state     | meaning
// S_IDLE    | not capturing, waiting for cap_start
// S_WAIT_VS | armed, waiting for a vsync falling edge (frame start)
// S_ACTIVE  | capturing lines until the vsync rising edge (frame end)
module cam_capture_ctrl #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  input  logic          cap_start,
  input  logic          cap_mode,
  input  logic          cap_abort,
`ifdef CAP_TESTPAT_EN
  input  logic          cap_tp,
`endif
  output logic [AW-1:0] mem_px_addr,
  output logic [11:0]   mem_px_data,
  output logic          mem_px_wr,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int LW = $clog2(IMG_H + 1);
  localparam int NW = $clog2(IMG_W * IMG_H + 1);
`ifdef CAP_TESTPAT_EN
  localparam int BAR_W = (IMG_W / 8 > 0) ? IMG_W / 8 : 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE} state_t;

  logic [2:0]    pclk_s_q, vs_s_q, href_s_q;
  logic [7:0]    data_s1_q, data_s2_q;
  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic          phase_q, phase_d;
  logic          seen_q, seen_d;
  logic [3:0]    red_q, red_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d;
  logic [NW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [11:0]   data_q, data_d;
  logic [11:0]   pix_new;
`ifdef CAP_TESTPAT_EN
  logic [2:0]    bar_idx;
`endif

  logic pe, href_s, vs_rise, vs_fall, href_fall;

  assign pe        = pclk_s_q[1] & ~pclk_s_q[2];
  assign href_s    = href_s_q[1];
  assign vs_rise   = vs_s_q[1] & ~vs_s_q[2];
  assign vs_fall   = ~vs_s_q[1] & vs_s_q[2];
  assign href_fall = ~href_s_q[1] & href_s_q[2];

  // Two-flop synchronisers for every camera pin, plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s_q  <= '0;
      vs_s_q    <= '0;
      href_s_q  <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      pclk_s_q  <= {pclk_s_q[1:0], CAM_pclk};
      vs_s_q    <= {vs_s_q[1:0], CAM_vsync};
      href_s_q  <= {href_s_q[1:0], CAM_href};
      data_s1_q <= CAM_px_data;
      data_s2_q <= data_s1_q;
    end
  end

  // Next-state logic: frame sequencing, byte packing, line accounting, and error flags.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    seen_d  = seen_q;
    red_d   = red_q;
    col_d   = col_q;
    line_d  = line_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
`ifdef CAP_TESTPAT_EN
    bar_idx = 3'(32'(col_q) / BAR_W);
    pix_new = cap_tp ? {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}}
                     : {red_q, data_s2_q};
`else
    pix_new = {red_q, data_s2_q};
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cap_start) begin
          state_d = S_WAIT_VS;
          mode_d  = cap_mode;
          err_d   = 1'b0;
        end
      end
      S_WAIT_VS: begin
        if (vs_fall) begin
          state_d = S_ACTIVE;
          col_d   = '0;
          line_d  = '0;
          phase_d = 1'b0;
          seen_d  = 1'b0;
          wcnt_d  = '0;
          addr_d  = '0;
        end
      end
      S_ACTIVE: begin
        if (!href_s) begin
          phase_d = 1'b0;
        end else if (pe) begin
          seen_d  = 1'b1;
          phase_d = ~phase_q;
          if (!phase_q) begin
            red_d = data_s2_q[3:0];
          end else if (col_q >= CW'(IMG_W) || line_q >= LW'(IMG_H)) begin
            // Out-of-frame pixel: dropped. col/line saturate so the frame stays flagged.
            err_d = 1'b1;
          end else begin
            wr_d   = 1'b1;
            addr_d = AW'(32'(line_q) * IMG_W + 32'(col_q));
            data_d = pix_new;
            col_d  = col_q + 1'b1;
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        if (href_fall && seen_q) begin
          if (phase_q || col_q < CW'(IMG_W)) err_d = 1'b1;
          col_d  = '0;
          seen_d = 1'b0;
          if (line_q < LW'(IMG_H)) line_d = line_q + 1'b1;
        end
        // wcnt_d already includes a write landing in this same cycle.
        if (vs_rise) begin
          done_d  = 1'b1;
          if (wcnt_d != NW'(IMG_W * IMG_H)) err_d = 1'b1;
          state_d = mode_q ? S_WAIT_VS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_abort) begin
      state_d = S_IDLE;
      wr_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      phase_q <= 1'b0;
      seen_q  <= 1'b0;
      red_q   <= '0;
      col_q   <= '0;
      line_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      seen_q  <= seen_d;
      red_q   <= red_d;
      col_q   <= col_d;
      line_q  <= line_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign mem_px_wr   = wr_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl on a reduced 16x6 frame. The camera is driven
// with pclk at a quarter of clk. Captured writes are compared against a
// line/pixel model of the expected frame contents.
module tb_cam_capture_ctrl;
  localparam int W  = 16;
  localparam int H  = 6;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          CAM_pclk = 1'b0, CAM_vsync = 1'b1, CAM_href = 1'b0;
  logic [7:0]    CAM_px_data = 8'h00;
  logic          cap_start = 1'b0, cap_mode = 1'b0, cap_abort = 1'b0;
`ifdef CAP_TESTPAT_EN
  logic          cap_tp = 1'b0;
`endif
  logic [AW-1:0] mem_px_addr;
  logic [11:0]   mem_px_data;
  logic          mem_px_wr, busy, frame_done, frame_err;

  cam_capture_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href), .CAM_px_data(CAM_px_data),
    .cap_start(cap_start), .cap_mode(cap_mode), .cap_abort(cap_abort),
`ifdef CAP_TESTPAT_EN
    .cap_tp(cap_tp),
`endif
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .mem_px_wr(mem_px_wr),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed traffic
  logic [AW-1:0] wr_addr[$];
  logic [11:0]   wr_data[$];
  int            wr_lat[$];
  int            done_cyc[$];
  logic          done_err[$];
  logic          done_busy[$];
  int            vs_cyc[$];
  int            last_rise = 0;

  // Stimulus frame and expected results
  int            ln_len[$];
  logic [7:0]    fb[$];
  logic [AW-1:0] ex_addr[$];
  logic [11:0]   ex_data[$];
  logic          ex_err_q[$];

  int wcnt, guard;

  always @(negedge clk) begin
    if (mem_px_wr === 1'b1) begin
      wr_addr.push_back(mem_px_addr);
      wr_data.push_back(mem_px_data);
      wr_lat.push_back(cyc - last_rise);
    end
    if (frame_done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_err.push_back(frame_err);
      done_busy.push_back(busy);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b, input logic hr);
    CAM_pclk = 1'b0; CAM_px_data = b; CAM_href = hr;
    tick(2);
    CAM_pclk = 1'b1; last_rise = cyc;
    tick(2);
  endtask

  task automatic blank(input int n);
    repeat (n) put_byte(8'($urandom), 1'b0);
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk); cap_start = 1'b1; cap_mode = m;
    @(negedge clk); cap_start = 1'b0; cap_mode = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_lat.delete();
    done_cyc.delete(); done_err.delete(); done_busy.delete(); vs_cyc.delete();
    ex_addr.delete(); ex_data.delete(); ex_err_q.delete();
  endtask

  // pat 0 = random bytes, 1 = 0F,00 repeating, 2 = 00,0F,00,0F,00,F0,00,F0 per line
  task automatic build(input int pat, input int nlines, input int sp_line, input int sp_len);
    logic [7:0] p8 [8];
    p8 = '{8'h00, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'hF0};
    ln_len.delete(); fb.delete();
    for (int l = 0; l < nlines; l++) begin
      int n = (l == sp_line) ? sp_len : 2 * W;
      ln_len.push_back(n);
      for (int i = 0; i < n; i++) begin
        case (pat)
          0:       fb.push_back(8'($urandom));
          1:       fb.push_back((i % 2) ? 8'h00 : 8'h0F);
          default: fb.push_back(p8[i % 8]);
        endcase
      end
    end
  endtask

  function automatic logic [11:0] bar(input int col);
    int idx;
    logic [2:0] b;
    idx = col / (W / 8);
    b = 3'(idx);
    return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
  endfunction

  // Expected frame: each line's bytes pair into pixels; pixels outside the
  // W x H window are dropped and flag an error, as do odd or short lines and
  // a frame whose write total is not W*H.
  task automatic model(input bit tp);
    int pos = 0;
    int l = 0;
    int wr = 0;
    logic err = 1'b0;
    foreach (ln_len[i]) begin
      int n = ln_len[i];
      int pairs = n / 2;
      if (n > 0) begin
        if (n % 2 != 0) err = 1'b1;
        if (pairs != W) err = 1'b1;
        for (int p = 0; p < pairs; p++) begin
          if (p < W && l < H) begin
            ex_addr.push_back(AW'(l * W + p));
            ex_data.push_back(tp ? bar(p) : {fb[pos + 2*p][3:0], fb[pos + 2*p + 1]});
            wr++;
          end else begin
            err = 1'b1;
          end
        end
        pos += n;
        l++;
      end
    end
    if (wr != W * H) err = 1'b1;
    ex_err_q.push_back(err);
  endtask

  task automatic drive_frame(input int start_after);
    int pos = 0;
    @(negedge clk);
    CAM_vsync = 1'b1; blank(2);
    CAM_vsync = 1'b0; blank(2);
    foreach (ln_len[l]) begin
      for (int i = 0; i < ln_len[l]; i++) put_byte(fb[pos + i], 1'b1);
      pos += ln_len[l];
      blank(3);
      if (l == start_after) pulse_start(1'b0);
    end
    CAM_vsync = 1'b1; vs_cyc.push_back(cyc);
    blank(4);
  endtask

  task automatic check_frame(input string tag, input int n_done, input logic busy_exp);
    int mism = 0;
    int first = -1;
    int lat_bad = 0;
    check({tag, "_nwr"}, wr_addr.size(), ex_addr.size());
    for (int i = 0; i < wr_addr.size() && i < ex_addr.size(); i++) begin
      if (wr_addr[i] !== ex_addr[i] || wr_data[i] !== ex_data[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    n_assert++;
    assert (mism == 0) else begin
      n_fail++;
      $error("FAIL %s_pix: %0d bad, first idx %0d got addr %0h data %0h expected addr %0h data %0h",
             tag, mism, first, wr_addr[first], wr_data[first], ex_addr[first], ex_data[first]);
    end
    foreach (wr_lat[i]) if (wr_lat[i] != 3) lat_bad++;
    check({tag, "_wr_latency_bad"}, lat_bad, 0);
    check({tag, "_ndone"}, done_cyc.size(), n_done);
    for (int i = 0; i < done_cyc.size() && i < vs_cyc.size() && i < ex_err_q.size(); i++) begin
      check({tag, "_done_latency"}, done_cyc[i] - vs_cyc[i], 3);
      check({tag, "_done_err"}, 32'(done_err[i]), 32'(ex_err_q[i]));
      check({tag, "_done_busy"}, 32'(done_busy[i]), 32'(busy_exp));
    end
    if (n_done > 0 && ex_err_q.size() > 0)
      check({tag, "_frame_err"}, 32'(frame_err), 32'(ex_err_q[ex_err_q.size() - 1]));
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_wr",   32'(mem_px_wr), 0);
    check("rst_addr", 32'(mem_px_addr), 0);
    check("rst_data", 32'(mem_px_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err",  32'(frame_err), 0);
    rst = 1'b0;
    tick(2);

    // Nominal single frame, 0F,00 repeating
    clear_mon(); build(1, H, -1, 0); model(1'b0);
    pulse_start(1'b0); drive_frame(-1);
    check_frame("nominal", 1, 1'b0);
    if (wr_data.size() > 0) check("nominal_px0", 32'(wr_data[0]), 32'h0F00);
    check("nominal_busy_after", 32'(busy), 0);

    // Repeating 8-byte pattern restarted each line
    clear_mon(); build(2, H, -1, 0); model(1'b0);
    pulse_start(1'b0); drive_frame(-1);
    check_frame("pattern", 1, 1'b0);
    if (wr_data.size() > W) begin
      check("pattern_px2", 32'(wr_data[2]), 32'h00F0);
      check("pattern_line1_px0", 32'(wr_data[W]), 32'h000F);
    end

    // Random bytes
    clear_mon(); build(0, H, -1, 0); model(1'b0);
    pulse_start(1'b0); drive_frame(-1);
    check_frame("random", 1, 1'b0);

    // Start mid-frame: partial frame skipped, next frame captured
    clear_mon(); build(0, H, -1, 0);
    drive_frame(1);
    check("midstart_nwr", wr_addr.size(), 0);
    check("midstart_ndone", done_cyc.size(), 0);
    check("midstart_busy", 32'(busy), 1);
    clear_mon(); build(0, H, -1, 0); model(1'b0);
    drive_frame(-1);
    check_frame("midstart_full", 1, 1'b0);

    // Short line 5, then cap_start clears the error
    clear_mon(); build(0, H, 5, 2 * W - 2); model(1'b0);
    pulse_start(1'b0); drive_frame(-1);
    check_frame("shortline", 1, 1'b0);
    pulse_start(1'b0);
    check("shortline_err_cleared", 32'(frame_err), 0);
    clear_mon(); build(0, H, -1, 0); model(1'b0);
    drive_frame(-1);
    check_frame("after_short", 1, 1'b0);

    // Over-long line plus an extra line
    clear_mon(); build(0, H + 1, 2, 2 * W + 2); model(1'b0);
    pulse_start(1'b0); drive_frame(-1);
    check_frame("overrun", 1, 1'b0);

    // Abort just before a write would be registered
    clear_mon(); build(0, H, -1, 0); model(1'b0);
    pulse_start(1'b0);
    fork
      drive_frame(-1);
      begin
        wcnt = 0; guard = 0;
        while (wcnt < 20 && guard < 4000) begin
          @(negedge clk); guard++;
          if (mem_px_wr === 1'b1) wcnt++;
        end
        check("abort_reach_20", wcnt, 20);
        tick(7);
        cap_abort = 1'b1;
        @(negedge clk);
        cap_abort = 1'b0;
        check("abort_wr_next", 32'(mem_px_wr), 0);
        check("abort_busy", 32'(busy), 0);
      end
    join
    check("abort_nwr", wr_addr.size(), 20);
    check("abort_ndone", done_cyc.size(), 0);
    if (wr_addr.size() >= 20) check("abort_last_addr", 32'(wr_addr[19]), 32'(ex_addr[19]));

    // Async reset while a write strobe is high
    clear_mon(); build(0, H, -1, 0);
    pulse_start(1'b0);
    fork
      drive_frame(-1);
      begin
        wcnt = 0; guard = 0;
        while (wcnt < 10 && guard < 4000) begin
          @(negedge clk); guard++;
          if (mem_px_wr === 1'b1) wcnt++;
        end
        check("rst_mid_reach_10", wcnt, 10);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_wr",   32'(mem_px_wr), 0);
        check("rst_mid_addr", 32'(mem_px_addr), 0);
        check("rst_mid_data", 32'(mem_px_data), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(frame_done), 0);
        check("rst_mid_err",  32'(frame_err), 0);
        tick(2);
        rst = 1'b0;
      end
    join
    check("rst_mid_nwr", wr_addr.size(), 10);
    check("rst_mid_ndone", done_cyc.size(), 0);

    // Continuous mode, two frames
    clear_mon();
    pulse_start(1'b1);
    build(0, H, -1, 0); model(1'b0); drive_frame(-1);
    build(0, H, -1, 0); model(1'b0); drive_frame(-1);
    check_frame("continuous", 2, 1'b1);
    if (wr_addr.size() > W * H) check("continuous_addr_restart", 32'(wr_addr[W * H]), 0);
    @(negedge clk); cap_abort = 1'b1;
    @(negedge clk); cap_abort = 1'b0;
    check("continuous_stop_busy", 32'(busy), 0);

`ifdef CAP_TESTPAT_EN
    // Colour bars
    cap_tp = 1'b1;
    clear_mon(); build(0, H, -1, 0); model(1'b1);
    pulse_start(1'b0); drive_frame(-1);
    check_frame("testpat", 1, 1'b0);
    if (wr_data.size() > 5) check("testpat_col5", 32'(wr_data[5]), 32'h00F0);
    cap_tp = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
